// File: rtl/mac_if.sv
// Sample/result bus of the multiply-accumulate neuron.
interface mac_if #(
   parameter int unsigned N_FEATURES = 3,
   parameter int unsigned WIDTH      = 32
);
   logic                          valid_i;
   logic [WIDTH*N_FEATURES-1:0]   x_flat;
   logic [WIDTH*N_FEATURES-1:0]   w_flat;
   logic [WIDTH-1:0]              b;
   logic                          valid_o;
   logic [WIDTH-1:0]              yhat;
   logic                          sat_o;

   // Sample producer: drives operands, observes results.
   modport master (
      output valid_i, x_flat, w_flat, b,
      input  valid_o, yhat, sat_o
   );

   // Neuron: consumes operands, drives results.
   modport slave (
      input  valid_i, x_flat, w_flat, b,
      output valid_o, yhat, sat_o
   );
endinterface

// File: rtl/mac.sv
// Single-stage pipelined fixed-point multiply-accumulate neuron with saturation.
module mac #(
   parameter int unsigned N_FEATURES = 3,
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned FRACTION   = 16
) (
   input  logic  clk,
   input  logic  rst_n,
   mac_if.slave  bus
);

   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned ACC_W  = 2 * WIDTH + $clog2(N_FEATURES) + 1;
   localparam int unsigned EXT_W  = ACC_W - WIDTH;

   // Clamp limits expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] MAX_VAL = {{(EXT_W + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_VAL = {{(EXT_W + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

   logic signed [ACC_W-1:0] acc_c;
   logic signed [ACC_W-1:0] res_c;
   logic        [WIDTH-1:0] yhat_c;
   logic                    sat_c;

   // Dot product plus aligned bias; accumulator is wide enough that it never overflows.
   always_comb begin
      logic signed [WIDTH-1:0]  x_e;
      logic signed [WIDTH-1:0]  w_e;
      logic signed [PROD_W-1:0] prod;
      acc_c = ACC_W'($signed(bus.b)) <<< FRACTION;
      for (int i = 0; i < int'(N_FEATURES); i++) begin
         x_e   = $signed(bus.x_flat[WIDTH*i +: WIDTH]);
         w_e   = $signed(bus.w_flat[WIDTH*i +: WIDTH]);
         prod  = PROD_W'(x_e) * PROD_W'(w_e);
         acc_c = acc_c + ACC_W'(prod);
      end
      res_c = acc_c >>> FRACTION;
   end

   // Clamp the realigned result to the signed WIDTH-bit range.
   always_comb begin
      yhat_c = res_c[WIDTH-1:0];
      sat_c  = 1'b0;
      if (res_c > MAX_VAL) begin
         yhat_c = {1'b0, {(WIDTH - 1){1'b1}}};
         sat_c  = 1'b1;
      end else if (res_c < MIN_VAL) begin
         yhat_c = {1'b1, {(WIDTH - 1){1'b0}}};
         sat_c  = 1'b1;
      end
   end

   // Output register: valid follows input valid, result held while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.valid_o <= 1'b0;
         bus.yhat    <= '0;
         bus.sat_o   <= 1'b0;
      end else begin
         bus.valid_o <= bus.valid_i;
         if (bus.valid_i) begin
            bus.yhat  <= yhat_c;
            bus.sat_o <= sat_c;
         end
      end
   end

endmodule

// File: tb/tb_mac.sv
// Directed scoreboard bench for the mac neuron (Q16.16, 3 features).
module tb_mac;

   localparam int unsigned NF = 3;
   localparam int unsigned W  = 32;
   localparam int unsigned F  = 16;

   typedef struct packed {
      logic [W-1:0] y;
      logic         s;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fails;
   exp_t sb[$];
   exp_t last_exp;
   exp_t got;

   mac_if #(.N_FEATURES(NF), .WIDTH(W)) bus ();

   mac #(.N_FEATURES(NF), .WIDTH(W), .FRACTION(F)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive(input bit v, input logic [W-1:0] x0, x1, x2, w0, w1, w2, bb);
      bus.valid_i = v;
      bus.x_flat  = {x2, x1, x0};
      bus.w_flat  = {w2, w1, w0};
      bus.b       = bb;
   endtask

   // Drive one sample (or idle) at the falling edge, then check just after the next rising edge.
   task automatic step(input string tag, input bit v,
                       input logic [W-1:0] x0, x1, x2, w0, w1, w2, bb,
                       input logic [W-1:0] ey, input bit es);
      exp_t e;
      @(negedge clk);
      drive(v, x0, x1, x2, w0, w1, w2, bb);
      if (v) begin
         e.y = ey;
         e.s = es;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, W'(bus.valid_o), W'(v));
      if (bus.valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            got = sb.pop_front();
            last_exp = got;
         end
      end
      chk({tag, "_yhat"}, bus.yhat, last_exp.y);
      chk({tag, "_sat"}, W'(bus.sat_o), W'(last_exp.s));
   endtask

   initial begin
      n_tests = 0;
      n_fails = 0;
      last_exp = '0;
      rst_n = 1'b0;
      drive(1'b0, '0, '0, '0, '0, '0, '0, '0);
      #1;
      chk("reset_async_valid", W'(bus.valid_o), 32'd0);
      chk("reset_async_yhat", bus.yhat, 32'd0);

      // Reset held 3 cycles with random valid traffic.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
         @(posedge clk);
         #1;
         chk("reset_hold_valid", W'(bus.valid_o), 32'd0);
         chk("reset_hold_yhat", bus.yhat, 32'd0);
         chk("reset_hold_sat", W'(bus.sat_o), 32'd0);
      end
      @(negedge clk);
      drive(1'b0, '0, '0, '0, '0, '0, '0, '0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_idle_valid", W'(bus.valid_o), 32'd0);
      chk("post_reset_idle_yhat", bus.yhat, 32'd0);

      step("pos_mix", 1'b1, 32'h0001_0000, 32'h0000_8000, 32'hFFFF_0000,
           32'h0002_0000, 32'h0004_0000, 32'hFFFD_0000, 32'h0000_4000, 32'h0007_4000, 1'b0);
      step("idle_hold1", 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
      step("neg_res", 1'b1, 32'hFFFE_0000, 32'h0003_0000, 32'h0000_4000,
           32'h0000_8000, 32'hFFFF_0000, 32'h0008_0000, 32'hFFFF_8000, 32'hFFFD_8000, 1'b0);
      step("pos_ovf", 1'b1, 32'h7FFF_0000, 32'h03E8_0000, 32'h03E8_0000,
           32'h03E8_0000, 32'h03E8_0000, 32'h03E8_0000, 32'h03E8_0000, 32'h7FFF_FFFF, 1'b1);
      step("neg_ovf", 1'b1, 32'h8000_0000, '0, '0, 32'h0002_0000, '0, '0, '0, 32'h8000_0000, 1'b1);
      step("exact_max", 1'b1, 32'h7FFF_FFFF, '0, '0, 32'h0001_0000, '0, '0, '0, 32'h7FFF_FFFF, 1'b0);
      step("exact_min", 1'b1, 32'h8000_0000, '0, '0, 32'h0001_0000, '0, '0, '0, 32'h8000_0000, 1'b0);
      step("trunc_floor", 1'b1, 32'hFFFF_FFFF, '0, '0, 32'h0000_8000, '0, '0, '0, 32'hFFFF_FFFF, 1'b0);
      step("zeros", 1'b1, '0, '0, '0, '0, '0, '0, '0, 32'h0000_0000, 1'b0);

      // Back-to-back stream then idle hold.
      step("stream_a", 1'b1, 32'h0001_0000, 32'h0000_8000, 32'hFFFF_0000,
           32'h0002_0000, 32'h0004_0000, 32'hFFFD_0000, 32'h0000_4000, 32'h0007_4000, 1'b0);
      step("stream_b", 1'b1, 32'hFFFE_0000, 32'h0003_0000, 32'h0000_4000,
           32'h0000_8000, 32'hFFFF_0000, 32'h0008_0000, 32'hFFFF_8000, 32'hFFFD_8000, 1'b0);
      step("stream_idle1", 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, '0, 1'b0);
      step("stream_idle2", 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, '0, 1'b0);

      // Mid-stream asynchronous reset discards outputs immediately.
      step("pre_rst", 1'b1, 32'h7FFF_0000, 32'h03E8_0000, 32'h03E8_0000,
           32'h03E8_0000, 32'h03E8_0000, 32'h03E8_0000, 32'h03E8_0000, 32'h7FFF_FFFF, 1'b1);
      @(negedge clk);
      drive(1'b1, 32'h0001_0000, '0, '0, 32'h0001_0000, '0, '0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", W'(bus.valid_o), 32'd0);
      chk("mid_rst_yhat", bus.yhat, 32'd0);
      chk("mid_rst_sat", W'(bus.sat_o), 32'd0);
      sb.delete();
      last_exp = '0;
      @(negedge clk);
      drive(1'b0, '0, '0, '0, '0, '0, '0, '0);
      rst_n = 1'b1;
      step("after_rst", 1'b1, 32'h0001_0000, '0, '0, 32'h0003_0000, '0, '0, 32'h0000_8000, 32'h0003_8000, 1'b0);
      step("after_rst_idle", 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mac.md
Name: mac

Overview:
- Fixed-point, single-stage pipelined multiply-accumulate neuron: yhat = sat(Σ x[i]·w[i] + b), all values signed Q(WIDTH−FRACTION).FRACTION (default Q16.16).
- Used as the dot-product/linear-regression core of the inference datapath.
- Consumes one flattened feature vector and weight vector per valid cycle.
- Produces a registered result one clock later, with a saturation flag.

Parameters:
- N_FEATURES, 3: number of feature/weight pairs per sample (≥1).
- WIDTH, 32: bit width of every signed fixed-point operand and of the result.
- FRACTION, 16: number of fractional bits in every operand and in the result (0 < FRACTION < WIDTH).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- valid_i  in  1  input sample valid; x_flat/w_flat/b are sampled when high.
- x_flat  in  WIDTH*N_FEATURES  signed features; element i = bits [WIDTH*i +: WIDTH], element 0 in the LSBs.
- w_flat  in  WIDTH*N_FEATURES  signed weights; same packing as x_flat.
- b  in  WIDTH  signed bias, Q format.
- valid_o  out  1  result valid, registered.
- yhat  out  WIDTH  signed saturated result, Q format, registered.
- sat_o  out  1  high when the yhat accompanying it was clamped.

Behaviour:
- Reset (rst_n=0, asynchronous): valid_o=0, yhat=0, sat_o=0 immediately; outputs hold these values until the first valid sample after release.
- Latency: exactly 1 cycle.
  - valid_o(n+1) = valid_i(n) on every edge.
  - When valid_i is high at edge n, yhat and sat_o carry that sample's result from edge n onward.
- When valid_i is low: yhat and sat_o hold their previous values; valid_o drops to 0 on the next edge.
- Throughput: one sample per cycle. Back-to-back valids produce back-to-back results; no stall or backpressure.
- Arithmetic, fully combinational before the single output register:
  - Each product p[i] = x[i]·w[i] is a full 2*WIDTH-bit signed product with 2*FRACTION fractional bits.
  - Bias is sign-extended and shifted left by FRACTION to the same alignment.
  - Accumulator width is 2*WIDTH + clog2(N_FEATURES) + 1 bits, signed; no intermediate overflow is possible.
  - Result = accumulator arithmetically shifted right by FRACTION (truncation toward −∞, no rounding).
- Saturation:
  - If result > 2^(WIDTH−1)−1: yhat = 0x7FFF…F and sat_o = 1.
  - If result < −2^(WIDTH−1): yhat = 0x800…0 and sat_o = 1.
  - Otherwise yhat = result[WIDTH−1:0] and sat_o = 0.
  - Clamping at exactly the limit value is not saturation (sat_o = 0).
- Reset asserted mid-stream: any in-flight result is discarded; outputs return to 0 asynchronously.
- Signed/zero operands: no special cases; zero inputs produce yhat = 0 with sat_o = 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs and valid_i=1 → valid_o=0, yhat=0, sat_o=0 throughout; first valid after release produces valid_o one cycle later.
- Positive mix: x=(1.0, 0.5, −1.0), w=(2.0, 4.0, −3.0), b=0.25, valid_i for one cycle → next edge valid_o=1, yhat=7.25 (0x00074000), sat_o=0.
- Negative result: x=(−2.0, 3.0, 0.25), w=(0.5, −1.0, 8.0), b=−0.5 → yhat=−2.5 (0xFFFD8000), sat_o=0, valid_o=1 one cycle after valid_i.
- Positive overflow: x=(32767.0, 1000.0, 1000.0), w=(1000.0, 1000.0, 1000.0), b=1000.0 → yhat=0x7FFFFFFF, sat_o=1, valid_o=1.
- Negative overflow: x=(−32768.0, 0, 0), w=(2.0, 0, 0), b=0 → yhat=0x80000000, sat_o=1.
- Streaming/hold: two back-to-back valid samples (positive mix, then negative-result sample), then valid_i=0 → results 7.25 then −2.5 on consecutive edges; valid_o falls one cycle after valid_i; yhat holds −2.5.
